ram_uart_dump: RTL

RAM_UART_DUMP -- requirements
Module: ram_uart_dump

---
 rtl/ram_uart_dump.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ram_uart_dump.sv
// Dumps a run of 16-bit block RAM words over a byte-wide UART link on command.
// Host sends CMD_DUMP, start address, word count (0 = 256); each word is sent high byte first.
module ram_uart_dump #(
  parameter logic [7:0] CMD_DUMP = 8'h44,
  parameter int         RD_LAT   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        new_rx_data_i,
  output logic [7:0]  tx_byte_o,
  output logic        new_tx_data_o,
  input  logic        tx_busy_i,
  output logic [7:0]  address_o,
  input  logic [15:0] data_i,
  output logic        busy_o,
  output logic        done_o
);

  // state     | meaning
  // IDLE      | waiting for the command byte
  // GET_ADDR  | waiting for the start address byte
  // GET_COUNT | waiting for the word count byte
  // RD_SET    | address_o presented to the RAM
  // RD_WAIT   | RAM latency; word captured on the last cycle
  // SEND_HI   | strobe high byte once the transmitter is free
  // WAIT_HI   | transmitter busy not yet valid after the strobe
  // SEND_LO   | strobe low byte once the transmitter is free
  // WAIT_LO   | same settling cycle, then fetch the next word
  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_COUNT, RD_SET, RD_WAIT,
    SEND_HI, WAIT_HI, SEND_LO, WAIT_LO
  } state_t;

  state_t      state, state_next;
  logic [7:0]  addr;
  logic [7:0]  tx_hold;
  logic [15:0] word;
  logic [8:0]  remaining;
  logic [7:0]  wait_cnt;

  // Strobe is combinational so it fires in the first cycle tx_busy_i is low;
  // tx_byte_o shows the held byte except in the strobe cycle itself.
  always_comb begin
    state_next    = state;
    new_tx_data_o = 1'b0;
    tx_byte_o     = tx_hold;
    case (state)
      IDLE:      if (new_rx_data_i && rx_byte_i == CMD_DUMP) state_next = GET_ADDR;
      GET_ADDR:  if (new_rx_data_i) state_next = GET_COUNT;
      GET_COUNT: if (new_rx_data_i) state_next = RD_SET;
      RD_SET:    state_next = RD_WAIT;
      RD_WAIT:   if (wait_cnt == 8'd0) state_next = SEND_HI;
      SEND_HI: begin
        if (!tx_busy_i) begin
          new_tx_data_o = 1'b1;
          tx_byte_o     = word[15:8];
          state_next    = WAIT_HI;
        end
      end
      WAIT_HI:   state_next = SEND_LO;
      SEND_LO: begin
        if (!tx_busy_i) begin
          new_tx_data_o = 1'b1;
          tx_byte_o     = word[7:0];
          state_next    = (remaining == 9'd1) ? IDLE : WAIT_LO;
        end
      end
      WAIT_LO:   state_next = RD_SET;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr      <= 8'd0;
      address_o <= 8'd0;
      tx_hold   <= 8'd0;
      word      <= 16'd0;
      remaining <= 9'd0;
      wait_cnt  <= 8'd0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (new_tx_data_o) tx_hold <= tx_byte_o;
      case (state)
        GET_ADDR: if (new_rx_data_i) addr <= rx_byte_i;
        GET_COUNT: begin
          if (new_rx_data_i) begin
            remaining <= (rx_byte_i == 8'd0) ? 9'd256 : {1'b0, rx_byte_i};
            busy_o    <= 1'b1;
            address_o <= addr;
          end
        end
        RD_SET: wait_cnt <= 8'(RD_LAT - 1);
        RD_WAIT: begin
          if (wait_cnt == 8'd0) word <= data_i;
          else                  wait_cnt <= wait_cnt - 8'd1;
        end
        SEND_LO: begin
          if (new_tx_data_o) begin
            remaining <= remaining - 9'd1;
            addr      <= addr + 8'd1;
            if (remaining == 9'd1) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
        end
        // address_o only moves as the FSM re-enters RD_SET
        WAIT_LO: address_o <= addr;
        default: ;
      endcase
    end
  end

endmodule
